tophat_run_sched: RTL and testbench

Run scheduler for the tophat tree-inference core. It sits between the host I/O decoder and the tree core and issues single-cycle run pulses when the model and feature vector are loaded and the core is idle, either on host request or continuously in auto mode. It tracks each inference to completion with a watchdog and queues the predictions in a small result FIFO for the host to pop.

---
 rtl/tophat_run_sched.sv | 135 +++++++++++++
 tb/tb_tophat_run_sched.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tophat_run_sched.sv
// Run scheduler for the tophat tree core: issues run pulses, watches each run
// with a watchdog and queues predictions in a small result FIFO.
//
// state | meaning
// IDLE  | waiting for ready plus a manual request or auto mode
// ISSUE | run_o high for one cycle, watchdog reset
// WAIT  | run in flight, waiting for core completion or watchdog expiry
module tophat_run_sched #(
  parameter int RES_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             clear_i,
  input  logic                             auto_i,
  input  logic                             run_req_i,
  input  logic                             model_loaded_i,
  input  logic                             features_loaded_i,
  input  logic                             core_busy_i,
  input  logic                             core_error_i,
  input  logic [7:0]                       core_pred_value_i,
  output logic                             run_o,
  input  logic                             res_pop_i,
  output logic                             res_valid_o,
  output logic [7:0]                       res_data_o,
  output logic [$clog2(RES_DEPTH+1)-1:0]   res_count_o,
  output logic                             err_o,
  output logic                             timeout_o,
  output logic                             busy_o,
  output logic [1:0]                       state_o
);

  localparam int CW = $clog2(RES_DEPTH+1);
  localparam int PW = $clog2(RES_DEPTH);
  localparam int WW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            pending_q;
  logic [WW-1:0]   wait_cnt;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [7:0]      mem [RES_DEPTH];

  logic ready, trigger, done, wait_last, issue, push, pop;

  assign ready     = model_loaded_i & features_loaded_i & ~core_busy_i &
                     (res_count_o < CW'(RES_DEPTH));
  // A request arriving in the same cycle as ready issues directly.
  assign trigger   = pending_q | run_req_i | auto_i;
  assign done      = (wait_cnt != '0) & ~core_busy_i;
  assign wait_last = (wait_cnt == WW'(TIMEOUT_CYCLES-1));
  assign issue     = ~clear_i & (state_q == S_IDLE) & ready & trigger;
  assign push      = ~clear_i & (state_q == S_WAIT) & done & ~core_error_i;
  assign pop       = ~clear_i & res_pop_i & (res_count_o != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (ready & trigger) state_d = S_ISSUE;
        S_ISSUE: state_d = S_WAIT;
        S_WAIT:  if (done | wait_last) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    run_o   = (state_q == S_ISSUE);
    busy_o  = (state_q != S_IDLE);
    state_o = state_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= 1'b0;
      wait_cnt  <= '0;
      err_o     <= 1'b0;
      timeout_o <= 1'b0;
    end else if (clear_i) begin
      pending_q <= 1'b0;
      wait_cnt  <= '0;
      err_o     <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      if (issue)          pending_q <= 1'b0;
      else if (run_req_i) pending_q <= 1'b1;
      if (state_q == S_ISSUE)     wait_cnt <= '0;
      else if (state_q == S_WAIT) wait_cnt <= wait_cnt + 1'b1;
      if ((state_q == S_WAIT) & done & core_error_i)  err_o     <= 1'b1;
      if ((state_q == S_WAIT) & ~done & wait_last)    timeout_o <= 1'b1;
    end
  end

  // Result FIFO; storage is reset so the head reads zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      res_count_o <= '0;
      for (int i = 0; i < RES_DEPTH; i++) mem[i] <= '0;
    end else if (clear_i) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      res_count_o <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= core_pred_value_i;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   res_count_o <= res_count_o + 1'b1;
        2'b01:   res_count_o <= res_count_o - 1'b1;
        default: res_count_o <= res_count_o;
      endcase
    end
  end

  assign res_valid_o = (res_count_o != '0);
  assign res_data_o  = mem[rd_ptr];

endmodule

// File: tb/tb_tophat_run_sched.sv
// Bench for tophat_run_sched: a vector table, directed corner sequences and a
// random phase, all checked against a queue-based reference model.
module tb_tophat_run_sched;
  localparam int DEPTH = 4;
  localparam int TMO   = 64;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       clear_i = 0, auto_i = 0, run_req_i = 0, model_loaded_i = 0;
  logic       features_loaded_i = 0, core_busy_i = 0, core_error_i = 0;
  logic [7:0] core_pred_value_i = 0;
  logic       res_pop_i = 0;
  logic       run_o, res_valid_o, err_o, timeout_o, busy_o;
  logic [7:0] res_data_o;
  logic [2:0] res_count_o;
  logic [1:0] state_o;

  always #5 clk = ~clk;

  tophat_run_sched #(.RES_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .clear_i(clear_i), .auto_i(auto_i),
    .run_req_i(run_req_i), .model_loaded_i(model_loaded_i),
    .features_loaded_i(features_loaded_i), .core_busy_i(core_busy_i),
    .core_error_i(core_error_i), .core_pred_value_i(core_pred_value_i),
    .run_o(run_o), .res_pop_i(res_pop_i), .res_valid_o(res_valid_o),
    .res_data_o(res_data_o), .res_count_o(res_count_o), .err_o(err_o),
    .timeout_o(timeout_o), .busy_o(busy_o), .state_o(state_o)
  );

  int total = 0, bad = 0;

  // reference model: phase 0 idle, 1 issue, 2 waiting
  int         m_st = 0, m_prev_st = 0, m_wait = 0;
  bit         m_pend = 0, m_err = 0, m_to = 0;
  logic [7:0] q[$];

  // core / loader emulation
  bit         core_en = 0, rand_mode = 0, fl_auto = 0;
  int         core_b = 1, busy_left = 0, fl_gap = 0;
  logic [7:0] pred_ctr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_prev_st = 0; m_wait = 0; m_pend = 0; m_err = 0; m_to = 0;
    q.delete();
  endtask

  task automatic model_update();
    int pre;
    bit ready, pop_ok, push;
    pre = q.size();
    push = 0;
    m_prev_st = m_st;
    if (clear_i) begin
      m_st = 0; m_pend = 0; m_err = 0; m_to = 0;
      q.delete();
    end else begin
      ready  = model_loaded_i && features_loaded_i && !core_busy_i && (pre < DEPTH);
      pop_ok = res_pop_i && (pre > 0);
      case (m_st)
        0: if (ready && (m_pend || run_req_i || auto_i)) begin m_st = 1; m_pend = 0; end
           else if (run_req_i) m_pend = 1;
        1: begin m_st = 2; m_wait = 0; if (run_req_i) m_pend = 1; end
        default: begin
          if (run_req_i) m_pend = 1;
          if (m_wait >= 1 && !core_busy_i) begin
            if (core_error_i) m_err = 1; else push = 1;
            m_st = 0;
          end else if (m_wait == TMO-1) begin
            m_to = 1; m_st = 0;
          end else m_wait++;
        end
      endcase
      if (pop_ok) void'(q.pop_front());
      if (push) q.push_back(core_pred_value_i);
    end
  endtask

  task automatic compare();
    chk("run", run_o, m_st == 1);
    chk("state", state_o, m_st);
    chk("busy", busy_o, m_st != 0);
    chk("count", res_count_o, q.size());
    chk("valid", res_valid_o, q.size() > 0);
    if (q.size() > 0) chk("data", res_data_o, q[0]);
    chk("err", err_o, m_err);
    chk("tmo", timeout_o, m_to);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    compare();
    if (core_en) begin
      if (m_prev_st == 1 && m_st == 2) begin
        busy_left = rand_mode ? (($urandom % 10 == 0) ? 80 : $urandom_range(1, 5)) : core_b;
        core_pred_value_i = rand_mode ? 8'($urandom) : pred_ctr;
        pred_ctr++;
      end else if (busy_left > 0) busy_left--;
      core_busy_i = (busy_left > 0);
      if (rand_mode) core_error_i = ($urandom % 8 == 0);
    end
    if (fl_auto) begin
      if (m_st == 1) begin features_loaded_i = 0; fl_gap = 2; end
      else if (!features_loaded_i) begin
        if (fl_gap > 0) fl_gap--; else features_loaded_i = 1;
      end
    end
  endtask

  typedef struct {
    bit ml, fl, busy, err, req, pop;
    logic [7:0] pred;
    bit run; logic [1:0] st; int cnt; bit vld; logic [7:0] data;
  } vec_t;
  vec_t tbl[8];

  int runs, waitc;
  bit sim_seen;
  logic [7:0] exp_d[4];

  initial begin
    tbl[0] = '{1,1,0,0,1,0,8'h5A, 1,2'd1,0,0,8'h00};
    tbl[1] = '{1,1,0,0,0,0,8'h5A, 0,2'd2,0,0,8'h00};
    tbl[2] = '{1,1,1,0,0,0,8'h5A, 0,2'd2,0,0,8'h00};
    tbl[3] = '{1,1,1,0,0,0,8'h5A, 0,2'd2,0,0,8'h00};
    tbl[4] = '{1,1,1,0,0,0,8'h5A, 0,2'd2,0,0,8'h00};
    tbl[5] = '{1,1,0,0,0,0,8'h5A, 0,2'd0,1,1,8'h5A};
    tbl[6] = '{1,1,0,0,0,1,8'h5A, 0,2'd0,0,0,8'h00};
    tbl[7] = '{1,1,0,0,0,1,8'h5A, 0,2'd0,0,0,8'h00};
    exp_d = '{8'h03, 8'h04, 8'h05, 8'h06};

    // reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", state_o, 0); chk("rst_run", run_o, 0); chk("rst_busy", busy_o, 0);
    chk("rst_valid", res_valid_o, 0); chk("rst_data", res_data_o, 0);
    chk("rst_count", res_count_o, 0); chk("rst_err", err_o, 0); chk("rst_tmo", timeout_o, 0);
    model_reset();
    @(negedge clk) rst_n = 1;

    // manual run vector table
    for (int i = 0; i < 8; i++) begin
      model_loaded_i = tbl[i].ml; features_loaded_i = tbl[i].fl;
      core_busy_i = tbl[i].busy; core_error_i = tbl[i].err;
      run_req_i = tbl[i].req; res_pop_i = tbl[i].pop; core_pred_value_i = tbl[i].pred;
      step();
      chk($sformatf("tbl%0d_run", i), run_o, tbl[i].run);
      chk($sformatf("tbl%0d_state", i), state_o, tbl[i].st);
      chk($sformatf("tbl%0d_count", i), res_count_o, tbl[i].cnt);
      chk($sformatf("tbl%0d_valid", i), res_valid_o, tbl[i].vld);
      if (tbl[i].vld) chk($sformatf("tbl%0d_data", i), res_data_o, tbl[i].data);
    end
    run_req_i = 0; res_pop_i = 0; core_busy_i = 0;
    core_en = 1; core_b = 1;

    // pending hold: request while model not loaded
    model_loaded_i = 0; run_req_i = 1; step(); run_req_i = 0;
    runs = 0;
    repeat (10) begin step(); runs += run_o; end
    chk("hold_no_run", runs, 0);
    model_loaded_i = 1; step();
    chk("hold_issue", run_o, 1);
    runs = 0;
    repeat (8) begin step(); runs += run_o; end
    chk("hold_single", runs, 0);
    res_pop_i = 1; step(); res_pop_i = 0;

    // auto mode filling the FIFO
    clear_i = 1; step(); clear_i = 0;
    pred_ctr = 1; core_b = 2; fl_auto = 1; auto_i = 1; runs = 0;
    repeat (60) begin step(); runs += run_o; end
    chk("auto_runs", runs, 4);
    chk("auto_full", res_count_o, 4);
    chk("auto_head", res_data_o, 1);
    res_pop_i = 1; step(); res_pop_i = 0;
    sim_seen = 0;
    for (int k = 0; k < 30 && !sim_seen; k++) begin
      res_pop_i = (m_st == 2 && m_wait >= 1 && !core_busy_i);
      step();
      if (res_pop_i) begin
        sim_seen = 1;
        chk("simul_count", res_count_o, 3);
      end
      res_pop_i = 0;
    end
    chk("simul_seen", sim_seen, 1);
    repeat (20) step();
    chk("refill_full", res_count_o, 4);
    runs = 0;
    repeat (15) begin step(); runs += run_o; end
    chk("full_no_run", runs, 0);
    auto_i = 0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("drain%0d", k), res_data_o, exp_d[k]);
      res_pop_i = 1; step(); res_pop_i = 0;
    end
    chk("drain_empty", res_valid_o, 0);

    // error completion then watchdog
    core_error_i = 1; run_req_i = 1; step(); run_req_i = 0;
    repeat (8) step();
    chk("err_set", err_o, 1);
    chk("err_nopush", res_count_o, 0);
    core_error_i = 0; core_b = 200;
    run_req_i = 1; step(); run_req_i = 0;
    waitc = 0;
    repeat (TMO + 10) begin step(); if (state_o == 2) waitc++; end
    chk("tmo_wait_cycles", waitc, TMO);
    chk("tmo_set", timeout_o, 1);
    chk("tmo_idle", state_o, 0);
    busy_left = 0; core_busy_i = 0;

    // clear during WAIT with two results queued
    core_b = 1;
    for (int r = 0; r < 2; r++) begin
      run_req_i = 1; step(); run_req_i = 0;
      repeat (6) step();
    end
    chk("clr_pre_count", res_count_o, 2);
    core_b = 20; run_req_i = 1; step(); run_req_i = 0;
    repeat (4) step();
    chk("clr_in_wait", state_o, 2);
    clear_i = 1; step(); clear_i = 0;
    chk("clr_count", res_count_o, 0); chk("clr_err", err_o, 0);
    chk("clr_tmo", timeout_o, 0); chk("clr_state", state_o, 0); chk("clr_run", run_o, 0);
    repeat (25) step();
    chk("clr_no_push", res_count_o, 0);

    // async reset during WAIT
    core_b = 1; run_req_i = 1; step(); run_req_i = 0;
    repeat (6) step();
    core_b = 30; run_req_i = 1; step(); run_req_i = 0;
    repeat (3) step();
    #2 rst_n = 0;
    #1;
    chk("arst_state", state_o, 0); chk("arst_run", run_o, 0); chk("arst_busy", busy_o, 0);
    chk("arst_valid", res_valid_o, 0); chk("arst_data", res_data_o, 0);
    chk("arst_count", res_count_o, 0); chk("arst_err", err_o, 0); chk("arst_tmo", timeout_o, 0);
    model_reset(); busy_left = 0; core_busy_i = 0;
    @(negedge clk) rst_n = 1;
    res_pop_i = 1; step(); res_pop_i = 0;
    chk("arst_pop_count", res_count_o, 0);
    chk("arst_pop_valid", res_valid_o, 0);

    // random phase
    rand_mode = 1;
    repeat (3000) begin
      model_loaded_i = ($urandom % 16 != 0);
      run_req_i = ($urandom % 6 == 0);
      res_pop_i = ($urandom % 3 == 0);
      clear_i = ($urandom % 60 == 0);
      if ($urandom % 40 == 0) auto_i = ~auto_i;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
